// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Control word bit order: pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic ifid_flush;
        logic idex_bubble;
        logic memwb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_BOOT   = ctrl_t'(7'b0111_111);
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(7'b0000_001);
    localparam ctrl_t CTRL_FLUSH  = ctrl_t'(7'b1111_110);
    localparam ctrl_t CTRL_LU     = ctrl_t'(7'b0011_010);
    localparam ctrl_t CTRL_NORMAL = ctrl_t'(7'b1111_000);

    // A redirect squashes the ID instruction, so it outranks a load-use stall.
    function automatic ctrl_t run_decision(input logic redirect, input logic lu);
        if (redirect) begin
            return CTRL_FLUSH;
        end else if (lu) begin
            return CTRL_LU;
        end
        return CTRL_NORMAL;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX.
module pipe_ctrl_hazard_detect (
    input  logic       id_valid,
    input  logic       id_rs1_re,
    input  logic       id_rs2_re,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       ex_valid,
    input  logic       ex_load,
    input  logic       ex_rd_we,
    input  logic [4:0] ex_rd_addr,
    output logic       lu
);

    logic [1:0] src_re;
    logic [4:0] src_addr [2];
    logic [1:0] src_hit;

    assign src_re      = {id_rs2_re, id_rs1_re};
    assign src_addr[0] = id_rs1_addr;
    assign src_addr[1] = id_rs2_addr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_re[gi] && (src_addr[gi] == ex_rd_addr);
        end
    endgenerate

    // x0 is hardwired to zero, so a load targeting it never forwards anything.
    assign lu = ex_valid && ex_load && ex_rd_we && (ex_rd_addr != 5'd0)
                && id_valid && (|src_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: boot hold, hazard/redirect/memory-stall
// arbitration and data-memory timeout. Optional counters via PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_rs1_re,
    input  logic        id_rs2_re,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_rd_we,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        exmem_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        memwb_bubble,
    output logic        mem_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_lu_stalls,
    output logic [31:0] perf_mem_stalls,
    output logic [31:0] perf_flushes
`endif
);

    localparam int         WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [7:0]          boot_cnt_q, boot_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [WAIT_W-1:0]   wait_inc;
    logic                mem_err_q, mem_err_d;
    logic                lu;
    ctrl_t               ctrl;
    ctrl_t               ctrl_out;

    pipe_ctrl_hazard_detect u_hazard (
        .id_valid    (id_valid),
        .id_rs1_re   (id_rs1_re),
        .id_rs2_re   (id_rs2_re),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .ex_valid    (ex_valid),
        .ex_load     (ex_load),
        .ex_rd_we    (ex_rd_we),
        .ex_rd_addr  (ex_rd_addr),
        .lu          (lu)
    );

    assign wait_inc = wait_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        ctrl       = CTRL_FREEZE;
        case (state_q)
            ST_BOOT: begin
                ctrl = CTRL_BOOT;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + 8'd1;
                end
            end
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end else begin
                    ctrl = run_decision(ex_redirect, lu);
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    ctrl    = run_decision(ex_redirect, lu);
                    state_d = ST_RUN;
                end else begin
                    // Counter stops at MEM_TIMEOUT because HALT is taken on that edge.
                    wait_cnt_d = wait_inc;
                    if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d   = ST_HALT;
                        mem_err_d = 1'b1;
                    end
                end
            end
            default: begin
                ctrl = CTRL_FREEZE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= '0;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Reset forces the boot pattern even before the state register has cleared.
    assign ctrl_out = rst ? CTRL_BOOT : ctrl;

    assign pc_we        = ctrl_out.pc_we;
    assign ifid_we      = ctrl_out.ifid_we;
    assign idex_we      = ctrl_out.idex_we;
    assign exmem_we     = ctrl_out.exmem_we;
    assign ifid_flush   = ctrl_out.ifid_flush;
    assign idex_bubble  = ctrl_out.idex_bubble;
    assign memwb_bubble = ctrl_out.memwb_bubble;
    assign mem_err      = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_lu_q,    perf_lu_d;
    logic [31:0] perf_mem_q,   perf_mem_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic        freeze_cyc;
    logic        decide_cyc;

    assign freeze_cyc = ((state_q == ST_RUN) && mem_req && !mem_ready)
                        || ((state_q == ST_MEM_WAIT) && !mem_ready);
    assign decide_cyc = ((state_q == ST_RUN) && !(mem_req && !mem_ready))
                        || ((state_q == ST_MEM_WAIT) && mem_ready);

    always_comb begin
        perf_lu_d    = perf_lu_q;
        perf_mem_d   = perf_mem_q;
        perf_flush_d = perf_flush_q;
        if (freeze_cyc) begin
            perf_mem_d = perf_mem_q + 32'd1;
        end
        if (decide_cyc && ex_redirect) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
        if (decide_cyc && !ex_redirect && lu) begin
            perf_lu_d = perf_lu_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_q    <= '0;
            perf_mem_q   <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_lu_q    <= perf_lu_d;
            perf_mem_q   <= perf_mem_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_lu_stalls  = perf_lu_q;
    assign perf_mem_stalls = perf_mem_q;
    assign perf_flushes    = perf_flush_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: RUN-state decision table plus boot, stall,
// redirect-during-wait and timeout sequences.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs1_re, id_rs2_re;
    logic [4:0] id_rs1_addr, id_rs2_addr;
    logic       ex_valid, ex_load, ex_rd_we;
    logic [4:0] ex_rd_addr;
    logic       ex_redirect, mem_req, mem_ready;
    logic       pc_we, ifid_we, idex_we, exmem_we;
    logic       ifid_flush, idex_bubble, memwb_bubble, mem_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_lu_stalls, perf_mem_stalls, perf_flushes;
    logic [31:0] perf_mem_base;
`endif

    int checks = 0;
    int errors = 0;

    // Expected {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble}
    localparam logic [6:0] E_NORMAL = 7'b1111_000;
    localparam logic [6:0] E_LU     = 7'b0011_010;
    localparam logic [6:0] E_FLUSH  = 7'b1111_110;
    localparam logic [6:0] E_FREEZE = 7'b0000_001;
    localparam logic [6:0] E_BOOT   = 7'b0111_111;

    pipe_ctrl #(
        .BOOT_CYCLES (4),
        .MEM_TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1_re    (id_rs1_re),
        .id_rs2_re    (id_rs2_re),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .ex_valid     (ex_valid),
        .ex_load      (ex_load),
        .ex_rd_we     (ex_rd_we),
        .ex_rd_addr   (ex_rd_addr),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .idex_we      (idex_we),
        .exmem_we     (exmem_we),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .memwb_bubble (memwb_bubble),
        .mem_err      (mem_err)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_lu_stalls  (perf_lu_stalls),
        .perf_mem_stalls (perf_mem_stalls),
        .perf_flushes    (perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       idv, r1e, r2e;
        logic [4:0] r1, r2;
        logic       exv, exl, exw;
        logic [4:0] rd;
        logic       redir, req, rdy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic idv, input logic r1e, input logic r2e,
                       input logic [4:0] r1, input logic [4:0] r2, input logic exv,
                       input logic exl, input logic exw, input logic [4:0] rd,
                       input logic redir, input logic req, input logic rdy,
                       input logic [6:0] exp);
        vec_t v;
        v.name = name; v.idv = idv; v.r1e = r1e; v.r2e = r2e; v.r1 = r1; v.r2 = r2;
        v.exv = exv; v.exl = exl; v.exw = exw; v.rd = rd;
        v.redir = redir; v.req = req; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.idv; id_rs1_re = v.r1e; id_rs2_re = v.r2e;
        id_rs1_addr = v.r1; id_rs2_addr = v.r2;
        ex_valid = v.exv; ex_load = v.exl; ex_rd_we = v.exw; ex_rd_addr = v.rd;
        ex_redirect = v.redir; mem_req = v.req; mem_ready = v.rdy;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1_re = 0; id_rs2_re = 0; id_rs1_addr = 0; id_rs2_addr = 0;
        ex_valid = 0; ex_load = 0; ex_rd_we = 0; ex_rd_addr = 0;
        ex_redirect = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [6:0] exp_ctrl, input logic exp_err);
        logic [7:0] got;
        logic [7:0] exp;
        #1;
        got = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble, mem_err};
        exp = {exp_ctrl, exp_err};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end else begin
            $display("ok   %s ctrl+err=%b", name, got);
        end
    endtask

    initial begin
        //   name             idv r1e r2e r1 r2 exv exl exw rd redir req rdy exp
        add("idle",            0,  0,  0,  0, 0,  0,  0,  0, 0,  0,   0,  0, E_NORMAL);
        add("lu_rs2_x5",       1,  0,  1,  0, 5,  1,  1,  1, 5,  0,   0,  0, E_LU);
        add("lu_rd_x0",        1,  0,  1,  0, 0,  1,  1,  1, 0,  0,   0,  0, E_NORMAL);
        add("lu_rs1_x7",       1,  1,  0,  7, 0,  1,  1,  1, 7,  0,   0,  0, E_LU);
        add("rs1_not_read",    1,  0,  0,  7, 7,  1,  1,  1, 7,  0,   0,  0, E_NORMAL);
        add("ex_not_load",     1,  1,  1,  5, 5,  1,  0,  1, 5,  0,   0,  0, E_NORMAL);
        add("id_invalid",      0,  1,  1,  5, 5,  1,  1,  1, 5,  0,   0,  0, E_NORMAL);
        add("ex_no_rd_we",     1,  1,  1,  5, 5,  1,  1,  0, 5,  0,   0,  0, E_NORMAL);
        add("ex_invalid",      1,  1,  1,  5, 5,  0,  1,  1, 5,  0,   0,  0, E_NORMAL);
        add("addr_differs",    1,  1,  1,  4, 6,  1,  1,  1, 5,  0,   0,  0, E_NORMAL);
        add("redirect_and_lu", 1,  0,  1,  0, 5,  1,  1,  1, 5,  1,   0,  0, E_FLUSH);
        add("redirect_only",   0,  0,  0,  0, 0,  0,  0,  0, 0,  1,   0,  0, E_FLUSH);
        add("mem_zero_wait",   0,  0,  0,  0, 0,  0,  0,  0, 0,  0,   1,  1, E_NORMAL);
        add("mem_zero_wait_lu",1,  1,  0, 9, 0,  1,  1,  1, 9,  0,   1,  1, E_LU);

        idle();
        rst = 1'b1;
        tick();
        tick();
        check("reset_held", E_BOOT, 1'b0);

        // Boot hold: four cycles of pc_we=0 after release, then RUN.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("boot_cycle_%0d", i + 1), E_BOOT, 1'b0);
            tick();
        end
        check("boot_done_run", E_NORMAL, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            check(vecs[i].name, vecs[i].exp, 1'b0);
            tick();
        end

        // Load-use lasts one cycle: load advances, ID sees a bubble in EX.
        idle();
        drive(vecs[1]);
        check("lu_seq_stall", E_LU, 1'b0);
        tick();
        ex_valid = 0;
        check("lu_seq_resume", E_NORMAL, 1'b0);
        tick();

        // Memory stall with ready arriving in cycle 4: three freeze cycles.
        idle();
`ifdef PIPE_CTRL_PERF_EN
        perf_mem_base = perf_mem_stalls;
`endif
        mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_freeze_%0d", i + 1), E_FREEZE, 1'b0);
            tick();
        end
        mem_ready = 1;
        check("stall_ready", E_NORMAL, 1'b0);
        tick();
        idle();
        check("stall_back_run", E_NORMAL, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (perf_mem_stalls - perf_mem_base !== 32'd3) begin
            errors++;
            $display("FAIL perf_mem_stalls got=%0d expected=3", perf_mem_stalls - perf_mem_base);
        end
`endif
        tick();

        // Redirect held through a stall takes effect in the ready cycle.
        mem_req = 1;
        ex_redirect = 1;
        check("redir_wait_run_freeze", E_FREEZE, 1'b0);
        tick();
        check("redir_wait_freeze", E_FREEZE, 1'b0);
        tick();
        mem_ready = 1;
        check("redir_wait_ready_flush", E_FLUSH, 1'b0);
        tick();
        idle();
        check("redir_wait_after", E_NORMAL, 1'b0);
        tick();

        // Timeout: RUN freeze cycle, then 8 MEM_WAIT cycles, then HALT.
        mem_req = 1;
        check("to_run_freeze", E_FREEZE, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("to_wait_%0d", i + 1), E_FREEZE, 1'b0);
            tick();
        end
        check("to_halt_err", E_FREEZE, 1'b1);
        mem_ready = 1;
        check("halt_ignores_ready", E_FREEZE, 1'b1);
        tick();
        check("halt_sticky", E_FREEZE, 1'b1);
        rst = 1;
        check("halt_rst_boot_out", E_BOOT, 1'b1);
        tick();
        idle();
        check("halt_rst_clears_err", E_BOOT, 1'b0);
        rst = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
